rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single write port of the register file among N_REQ requesters (e.g. WB stage,
//  memory/load unit, interrupt context-save unit). Round-robin arbitration with valid/ready
//  handshake, optional multi-cycle lock for multi-word writes, and a registered write stage
//  that drives the register file's in_data/write-enable one cycle after acceptance.
// PARAMETERS
//  N_REQ   2   number of requesters (>=2)
//  DATA_W  16  write data width
//  ADDR_W  3   register address width
// PORTS
//  clk        in   1             clock; all state updates on posedge
//  reset      in   1             asynchronous, active-low (0 = reset)
//  req_valid  in   N_REQ         requester i has a write pending
//  req_lock   in   N_REQ         requester i wants to keep the port after this transfer
//  req_addr   in   N_REQ*ADDR_W  slice i = target register of requester i
//  req_data   in   N_REQ*DATA_W  slice i = write data of requester i
//  req_ready  out  N_REQ         one-hot (or zero) grant; transfer = valid&ready at posedge
//  stall      in   1             1 = no new grants this cycle
//  rf_we      out  1             registered write enable to register file
//  rf_waddr   out  ADDR_W        registered write address
//  rf_wdata   out  DATA_W        registered write data
//  grant_id   out  clog2(N_REQ)  index of requester whose write is on rf_* (valid when rf_we)
//  locked     out  1             1 while in LOCKED state
// BEHAVIOUR
//  - Reset (reset=0, async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0,
//    locked=0, state=IDLE, last_grant=N_REQ-1 (requester 0 highest priority first).
//    An in-flight write is dropped; req_ready is 0 while reset=0.
//  - req_ready is combinational from req_valid, stall, state, last_grant; at most one bit set.
//  - Requester must hold addr/data/lock stable while valid=1 until the transfer edge.
//  - States: IDLE, LOCKED(owner).
//    IDLE: if stall=0, grant first valid requester searching last_grant+1, +2 ... (mod N_REQ).
//      On transfer: last_grant<=winner; if req_lock[winner]=1 -> LOCKED(owner=winner).
//    LOCKED: only owner may get ready (if stall=0); others held off.
//      Transfer with req_lock=0 -> IDLE. Owner req_valid=0 for a cycle -> IDLE (lock abandoned).
//      Transfer with req_lock=1 -> stay LOCKED.
//  - Latency: transfer at edge k -> rf_we=1 with that addr/data for cycle k..k+1 (exactly one
//    cycle); no transfer at edge -> rf_we=0 next cycle, rf_waddr/rf_wdata hold last value.
//  - Throughput: one write per cycle, back-to-back, no bubbles.
//  - stall=1: req_ready=0, no state change, lock retained; rf_we=0 from the next cycle.
//  - Same address from two requesters in one cycle: only the winner writes; loser writes in a
//    later cycle, so the loser's value is the final register content (no merging).
//  - last_grant wraps N_REQ-1 -> 0. No requester starves: waiting requester granted within
//    N_REQ transfers when no lock is held.
//  - No combinational path from rf_* outputs to inputs; req_ready never depends on rf_we.
// TESTING
//  1 Reset: assert reset=0 mid-write (rf_we=1) -> rf_we=0, rf_waddr=0, rf_wdata=0 immediately,
//    req_ready=0; release -> req0 gets priority over req1 on simultaneous valid.
//  2 Round-robin: req0,req1 valid continuously (addr 1/2, data 0xAAAA/0x5555) -> grants alternate
//    0,1,0,1; rf_we=1 every cycle, rf_waddr 1,2,1,2 one cycle after each grant.
//  3 Lock: req1 valid+lock for 3 transfers (0x0001..0x0003 to r5,r6,r7), req0 valid throughout
//    -> req0 ready=0 during lock, locked=1; req0 granted the cycle after req1's lock=0 transfer.
//  4 Abandon: LOCKED owner drops valid one cycle -> state IDLE, locked=0, other requester granted.
//  5 Stall: stall=1 for 2 cycles with both valid -> req_ready=0, rf_we=0 (from next cycle),
//    last_grant unchanged; stall=0 resumes with the previously-due requester.
//  6 Same-address collision: req0 r3=0x1111, req1 r3=0x2222 same cycle -> two writes in order
//    0x1111 then 0x2222; model register file ends with r3=0x2222.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Requester-side bundle of the register-file write arbiter.
// Master = requesters, slave = arbiter.
interface rf_write_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    stall;

  modport master (
    output req_valid, req_lock, req_addr, req_data, stall,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, stall,
    output req_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port
// with optional lock and a registered write stage.
module rf_write_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  rf_write_arbiter_if.slave        req,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;

  logic            rr_hit;
  logic [IDW-1:0]  rr_idx;
  logic [IDW-1:0]  win;
  logic [N_REQ-1:0] ready;
  logic            xfer;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic            lock_sel;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [IDW-1:0]    gid_q;

  // Round-robin search: nearest valid requester after last_grant
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req.req_valid[(int'(last_q) + k) % N_REQ]) begin
        rr_hit = 1'b1;
        rr_idx = IDW'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  // FSM state register plus round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // FSM next state: lock follows the winner's lock bit
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (xfer) begin
      last_d = win;
      if (lock_sel) begin
        state_d = LOCKED;
        owner_d = win;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == LOCKED && !req.stall &&
                 !req.req_valid[owner_q]) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: one-hot ready, gated by reset and stall
  always_comb begin
    ready = '0;
    win   = rr_idx;
    unique case (state_q)
      IDLE: begin
        win = rr_idx;
        if (reset && !req.stall && rr_hit) ready[rr_idx] = 1'b1;
      end
      LOCKED: begin
        win = owner_q;
        if (reset && !req.stall && req.req_valid[owner_q])
          ready[owner_q] = 1'b1;
      end
      default: ready = '0;
    endcase
  end

  assign xfer          = |ready;
  assign req.req_ready = ready;

  // Winner's payload selection
  always_comb begin
    addr_sel = req.req_addr[int'(win)*ADDR_W +: ADDR_W];
    data_sel = req.req_data[int'(win)*DATA_W +: DATA_W];
    lock_sel = req.req_lock[win];
  end

  // Registered write stage; payload holds when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      gid_q      <= '0;
    end else begin
      rf_we_q <= xfer;
      if (xfer) begin
        rf_waddr_q <= addr_sel;
        rf_wdata_q <= data_sel;
        gid_q      <= win;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = gid_q;
  assign locked   = (state_q == LOCKED);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus
// random traffic against a rule-level model.
module tb_rf_write_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus();

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [0:0]    grant_id;
  logic          locked;

  rf_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .grant_id (grant_id),
    .locked   (locked)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m_last, m_owner, m_waddr, m_wdata, m_gid, last_xfer;
  bit m_lock, m_we;
  logic [DW-1:0] exp_rf [8];
  logic [DW-1:0] obs_rf [8];
  logic [AW+DW+2:0] exp_v, got_v;

  function automatic int m_grant();
    if (!reset || bus.stall) return -1;
    if (m_lock) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++)
      if (bus.req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] v;
    int g;
    v = '0;
    g = m_grant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_lock = 0; m_owner = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0; m_gid = 0;
    last_xfer = -1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input int a0, input int d0,
                       input int a1, input int d1, input logic st);
    bus.req_valid = v;
    bus.req_lock  = l;
    bus.req_addr  = {AW'(a1), AW'(a0)};
    bus.req_data  = {DW'(d1), DW'(d0)};
    bus.stall     = st;
  endtask

  // One clock: model follows the rules, observed writes land in obs_rf
  task automatic tick();
    int g;
    g = m_grant();
    @(posedge clk);
    m_we = (g >= 0);
    if (g >= 0) begin
      m_waddr = int'(bus.req_addr[g*AW +: AW]);
      m_wdata = int'(bus.req_data[g*DW +: DW]);
      m_gid   = g;
      exp_rf[m_waddr] = DW'(m_wdata);
      m_last  = g;
      m_lock  = bus.req_lock[g];
      m_owner = g;
    end else if (m_lock && !bus.stall && !bus.req_valid[m_owner]) begin
      m_lock = 0;
    end
    last_xfer = g;
    #1;
    if (rf_we) obs_rf[rf_waddr] = rf_wdata;
    @(negedge clk);
    exp_v = {m_we, AW'(m_waddr), DW'(m_wdata), 1'(m_gid), m_lock};
    got_v = {rf_we, rf_waddr, rf_wdata, grant_id, locked};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    model_reset();
    for (int i = 0; i < 8; i++) begin exp_rf[i] = '0; obs_rf[i] = '0; end
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 2'b00 || rf_we !== 1'b0)
      $display("FAIL reset_hold ready=%b we=%b want 00/0", bus.req_ready, rf_we);
    else n_pass++;
    reset = 1'b1;
    drive(2'b01, 2'b00, 4, 'h1234, 0, 0, 1'b0);
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL reset_first ready=%b want 01", bus.req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (got_v !== exp_v || rf_we !== 1'b1)
      $display("FAIL reset_write got %h want %h", got_v, exp_v);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id, locked} !== '0 ||
        bus.req_ready !== 2'b00)
      $display("FAIL reset_async out=%b/%h/%h/%b/%b ready=%b want zeros",
               rf_we, rf_waddr, rf_wdata, grant_id, locked, bus.req_ready);
    else n_pass++;
    model_reset();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 2'b00, 1, 'hAAAA, 2, 'h5555, 1'b0);
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL reset_prio ready=%b want 01", bus.req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (got_v !== exp_v) $display("FAIL reset_prio_wr got %h want %h", got_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int prev;
    prev = m_gid;
    drive(2'b11, 2'b00, 1, 'hAAAA, 2, 'h5555, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (bus.req_ready !== exp_ready())
        $display("FAIL rr_ready got %b want %b", bus.req_ready, exp_ready());
      else n_pass++;
      tick();
      n_chk++;
      if (got_v !== exp_v || rf_we !== 1'b1 || int'(grant_id) == prev ||
          int'(rf_waddr) != int'(grant_id) + 1)
        $display("FAIL rr_write got %h want %h prev_id %0d", got_v, exp_v, prev);
      else n_pass++;
      prev = int'(grant_id);
    end
  endtask

  task automatic test_lock();
    int j, cyc;
    drive(2'b01, 2'b00, 0, 'h0BAD, 0, 0, 1'b0);
    tick();
    j = 0; cyc = 0;
    while (j < 3 && cyc < 10) begin
      drive(2'b11, {1'(j < 2), 1'b0}, 2, 'h0CAF, 5 + j, j + 1, 1'b0);
      #1;
      n_chk++;
      if (bus.req_ready !== exp_ready() || (m_lock && bus.req_ready[0] !== 1'b0))
        $display("FAIL lock_ready got %b want %b", bus.req_ready, exp_ready());
      else n_pass++;
      tick();
      n_chk++;
      if (got_v !== exp_v) $display("FAIL lock_write got %h want %h", got_v, exp_v);
      else n_pass++;
      if (last_xfer == 1) j++;
      cyc++;
    end
    n_chk++;
    if (j != 3) $display("FAIL lock_timeout transfers %0d want 3", j);
    else n_pass++;
    drive(2'b01, 2'b00, 2, 'h0CAF, 0, 0, 1'b0);
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b01 || locked !== 1'b0)
      $display("FAIL lock_release ready=%b locked=%b want 01/0", bus.req_ready, locked);
    else n_pass++;
    tick();
  endtask

  task automatic test_abandon();
    drive(2'b11, 2'b10, 1, 'h0011, 6, 'h0066, 1'b0);
    #1;
    tick();
    n_chk++;
    if (locked !== 1'b1 || got_v !== exp_v)
      $display("FAIL abandon_lock locked=%b got %h want %h", locked, got_v, exp_v);
    else n_pass++;
    drive(2'b01, 2'b00, 1, 'h0011, 0, 0, 1'b0);
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL abandon_hold ready=%b want 00", bus.req_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (locked !== 1'b0 || rf_we !== 1'b0)
      $display("FAIL abandon_idle locked=%b we=%b want 0/0", locked, rf_we);
    else n_pass++;
    drive(2'b11, 2'b00, 1, 'h0011, 6, 'h0077, 1'b0);
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL abandon_other ready=%b want 01", bus.req_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    drive(2'b11, 2'b00, 1, 'hAAAA, 2, 'h5555, 1'b0);
    #1;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.stall = 1'b1;
      #1;
      n_chk++;
      if (bus.req_ready !== 2'b00)
        $display("FAIL stall_ready ready=%b want 00", bus.req_ready);
      else n_pass++;
      tick();
      n_chk++;
      if (rf_we !== 1'b0 || got_v !== exp_v)
        $display("FAIL stall_we got %h want %h", got_v, exp_v);
      else n_pass++;
    end
    bus.stall = 1'b0;
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b01)
      $display("FAIL stall_resume ready=%b want 01", bus.req_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_collision();
    drive(2'b10, 2'b00, 0, 0, 4, 'h4444, 1'b0);
    #1;
    tick();
    drive(2'b11, 2'b00, 3, 'h1111, 3, 'h2222, 1'b0);
    #1;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1111)
      $display("FAIL coll_first got %b/%h/%h want 1/3/1111", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    bus.req_valid[0] = 1'b0;
    #1;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h2222)
      $display("FAIL coll_second got %b/%h/%h want 1/3/2222", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    n_chk++;
    if (obs_rf[3] !== 16'h2222)
      $display("FAIL coll_final r3=%h want 2222", obs_rf[3]);
    else n_pass++;
  endtask

  task automatic test_random();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_xfer == i || !bus.req_valid[i]) begin
          bus.req_valid[i]         = ($urandom_range(0, 3) != 0);
          bus.req_lock[i]          = ($urandom_range(0, 3) == 0);
          bus.req_addr[i*AW +: AW] = AW'($urandom);
          bus.req_data[i*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.stall = ($urandom_range(0, 7) == 0);
      #1;
      n_chk++;
      if (bus.req_ready !== exp_ready())
        $display("FAIL rand_ready cyc %0d got %b want %b", c, bus.req_ready, exp_ready());
      else n_pass++;
      tick();
      n_chk++;
      if (got_v !== exp_v)
        $display("FAIL rand_write cyc %0d got %h want %h", c, got_v, exp_v);
      else n_pass++;
    end
    for (int r = 0; r < 8; r++) begin
      n_chk++;
      if (obs_rf[r] !== exp_rf[r])
        $display("FAIL rand_rf r%0d got %h want %h", r, obs_rf[r], exp_rf[r]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_abandon();
    test_stall();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
